// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the LEGv8 datapath.
// CPU top, decode and the register file all pull their defaults from here.
package regfile_pkg;

   localparam int REG_DATA_W   = 64;
   localparam int REG_COUNT    = 32;
   localparam int REG_ZERO_IDX = 31;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [63:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port.
// Priority is: hardwired zero, then same-cycle write bypass, then stored entry.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = REG_DATA_W,
   parameter int NUM_REGS = REG_COUNT,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = REG_ZERO_IDX,
   parameter int BYPASS   = 1
) (
   input  logic [ADDR_W-1:0]                 rd_addr,
   input  logic [NUM_WR-1:0]                 wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]     wr_addr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]     wr_data,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]   regs,
   output logic [DATA_W-1:0]                 rd_data
);

   // ZERO_REG == NUM_REGS disables the hardwired zero entirely.
   localparam bit              ZERO_EN  = (ZERO_REG < NUM_REGS);
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

   // Later write ports override earlier ones, so port 1 wins a bypass tie.
   always_comb begin
      rd_data = regs[rd_addr];
      if (BYPASS != 0) begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w] == rd_addr)) begin
               rd_data = wr_data[w];
            end
         end
      end
      if (ZERO_EN && (rd_addr == ZERO_IDX)) begin
         rd_data = '0;
      end
   end

endmodule

// File: rtl/multiport_regfile.sv
// Parametrised multi-port register file: storage, write priority decode,
// registered write-conflict flag and NUM_RD generated read ports.
module multiport_regfile
   import regfile_pkg::*;
#(
   parameter int DATA_W   = REG_DATA_W,
   parameter int NUM_REGS = REG_COUNT,
   localparam int ADDR_W  = $clog2(NUM_REGS),
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = REG_ZERO_IDX,
   parameter int BYPASS   = 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]     ReadRegister,
   output logic [NUM_RD-1:0][DATA_W-1:0]     ReadData,
   input  logic [NUM_WR-1:0]                 RegWrite,
   input  logic [NUM_WR-1:0][ADDR_W-1:0]     WriteRegister,
   input  logic [NUM_WR-1:0][DATA_W-1:0]     WriteData,
   output logic                              WrConflict
);

   localparam bit                ZERO_EN  = (ZERO_REG < NUM_REGS);
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
   logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
   logic                            wr_conflict_q;
   logic                            wr_conflict_d;

   // Ports applied in ascending order so port 1 overwrites port 0 on a collision.
   always_comb begin
      regs_d = regs_q;
      for (int w = 0; w < NUM_WR; w++) begin
         if (RegWrite[w] && !(ZERO_EN && (WriteRegister[w] == ZERO_IDX))) begin
            regs_d[WriteRegister[w]] = WriteData[w];
         end
      end
      if (ZERO_EN) begin
         regs_d[ZERO_IDX] = '0;
      end
   end

   always_comb begin
      wr_conflict_d = 1'b0;
      if (NUM_WR == 2) begin
         wr_conflict_d = RegWrite[0] && RegWrite[NUM_WR-1] &&
                         (WriteRegister[0] == WriteRegister[NUM_WR-1]) &&
                         !(ZERO_EN && (WriteRegister[0] == ZERO_IDX));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q        <= '0;
         wr_conflict_q <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   assign WrConflict = wr_conflict_q;

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      regfile_read_port #(
         .DATA_W   (DATA_W),
         .NUM_REGS (NUM_REGS),
         .ADDR_W   (ADDR_W),
         .NUM_WR   (NUM_WR),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd (
         .rd_addr (ReadRegister[r]),
         .wr_en   (RegWrite),
         .wr_addr (WriteRegister),
         .wr_data (WriteData),
         .regs    (regs_q),
         .rd_data (ReadData[r])
      );
   end

endmodule

// File: tb/tb_multiport_regfile.sv
// Randomised self-checking bench for multiport_regfile: a 4-read/2-write bypassing
// instance and a 32-bit, 16-entry, no-zero, non-bypassing instance.
module tb_multiport_regfile;

   logic clk;
   logic reset;

   logic [3:0][4:0]  rd_a;
   logic [3:0][63:0] rdata_a;
   logic [1:0]       we_a;
   logic [1:0][4:0]  wa_a;
   logic [1:0][63:0] wd_a;
   logic             conf_a;

   logic [1:0][3:0]  rd_b;
   logic [1:0][31:0] rdata_b;
   logic [0:0]       we_b;
   logic [0:0][3:0]  wa_b;
   logic [0:0][31:0] wd_b;
   logic             conf_b;

   logic [63:0] mem_a [32];
   logic [31:0] mem_b [16];
   logic        exp_conf_a;

   int checks = 0;
   int errors = 0;

   multiport_regfile #(
      .DATA_W(64), .NUM_REGS(32), .NUM_RD(4), .NUM_WR(2), .ZERO_REG(31), .BYPASS(1)
   ) dut_a (
      .clk(clk), .reset(reset),
      .ReadRegister(rd_a), .ReadData(rdata_a),
      .RegWrite(we_a), .WriteRegister(wa_a), .WriteData(wd_a),
      .WrConflict(conf_a)
   );

   multiport_regfile #(
      .DATA_W(32), .NUM_REGS(16), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(16), .BYPASS(0)
   ) dut_b (
      .clk(clk), .reset(reset),
      .ReadRegister(rd_b), .ReadData(rdata_b),
      .RegWrite(we_b), .WriteRegister(wa_b), .WriteData(wd_b),
      .WrConflict(conf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural view of a read on the bypassing instance.
   function automatic logic [63:0] model_a(input logic [4:0] idx);
      if (idx == 5'd31) return 64'd0;
      if (we_a[1] && wa_a[1] == idx) return wd_a[1];
      if (we_a[0] && wa_a[0] == idx) return wd_a[0];
      return mem_a[idx];
   endfunction

   function automatic logic [31:0] model_b(input logic [3:0] idx);
      return mem_b[idx];
   endfunction

   task automatic clear_models();
      for (int i = 0; i < 32; i++) mem_a[i] = '0;
      for (int i = 0; i < 16; i++) mem_b[i] = '0;
      exp_conf_a = 1'b0;
   endtask

   task automatic commit_models();
      if (reset) begin
         exp_conf_a = we_a[0] && we_a[1] && (wa_a[0] == wa_a[1]) && (wa_a[0] != 5'd31);
         for (int w = 0; w < 2; w++)
            if (we_a[w] && wa_a[w] != 5'd31) mem_a[wa_a[w]] = wd_a[w];
         if (we_b[0]) mem_b[wa_b[0]] = wd_b[0];
      end else begin
         exp_conf_a = 1'b0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      commit_models();
      #1;
   endtask

   task automatic idle_inputs();
      we_a = '0;
      we_b = '0;
   endtask

   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         for (int w = 0; w < 2; w++) begin
            we_a[w] = 1'($urandom);
            wa_a[w] = ($urandom % 2) ? 5'($urandom_range(28, 31)) : 5'($urandom);
            wd_a[w] = {$urandom, $urandom};
         end
         for (int r = 0; r < 4; r++)
            rd_a[r] = ($urandom % 2) ? 5'($urandom_range(28, 31)) : 5'($urandom);
         we_b[0] = 1'($urandom);
         wa_b[0] = 4'($urandom);
         wd_b[0] = $urandom;
         rd_b[0] = ($urandom % 2) ? wa_b[0] : 4'($urandom);
         rd_b[1] = 4'($urandom);
         #1;
         for (int r = 0; r < 4; r++) begin
            checks++;
            if (rdata_a[r] !== model_a(rd_a[r])) begin
               errors++;
               $display("[TB] FAIL rand_read_a%0d: got %h expected %h", r, rdata_a[r], model_a(rd_a[r]));
            end
         end
         for (int r = 0; r < 2; r++) begin
            checks++;
            if (rdata_b[r] !== model_b(rd_b[r])) begin
               errors++;
               $display("[TB] FAIL rand_read_b%0d: got %h expected %h", r, rdata_b[r], model_b(rd_b[r]));
            end
         end
         step();
         checks++;
         if (conf_a !== exp_conf_a || conf_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_conflict: got %b/%b expected %b/0", conf_a, conf_b, exp_conf_a);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      wa_a = '0; wd_a = '0; wa_b = '0; wd_b = '0;
      rd_a = '0; rd_b = '0;
      clear_models();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      rd_a = {5'd3, 5'd9, 5'd17, 5'd30};
      #1;
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (rdata_a[r] !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_read%0d: got %h expected 0", r, rdata_a[r]);
         end
      end
      checks++;
      if (conf_a !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_conflict: got %b expected 0", conf_a);
      end
      @(negedge clk);
      we_a = 2'b11;
      wa_a = {5'd3, 5'd3};
      wd_a = {64'hDEAD_BEEF, 64'd1};
      step();
      checks++;
      if (conf_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_pre_conflict: got %b expected 1", conf_a);
      end
      @(negedge clk);
      idle_inputs();
      rd_a[0] = 5'd3;
      #1;
      checks++;
      if (rdata_a[0] !== 64'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL reset_pre_x3: got %h expected %h", rdata_a[0], 64'hDEAD_BEEF);
      end
      #1;
      reset = 1'b0;
      clear_models();
      #1;
      checks++;
      if (rdata_a[0] !== 64'd0 || conf_a !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_async: got %h/%b expected 0/0", rdata_a[0], conf_a);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic_write();
      logic [31:0] vals [2];
      vals[0] = 32'h5555;
      vals[1] = 32'h1234;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         we_a = 2'b01; wa_a[0] = 5'd5; wd_a[0] = 64'(vals[i]);
         rd_a = {4{5'd5}};
         we_b = 1'b1; wa_b[0] = 4'd5; wd_b[0] = vals[i];
         rd_b = {2{4'd5}};
         #1;
         checks++;
         if (rdata_a[0] !== 64'(vals[i])) begin
            errors++;
            $display("[TB] FAIL basic_bypass: got %h expected %h", rdata_a[0], 64'(vals[i]));
         end
         checks++;
         if (rdata_b[0] !== model_b(4'd5)) begin
            errors++;
            $display("[TB] FAIL basic_nobypass_old: got %h expected %h", rdata_b[0], model_b(4'd5));
         end
         step();
         @(negedge clk);
         idle_inputs();
         #1;
         checks++;
         if (rdata_a[3] !== 64'(vals[i]) || rdata_b[1] !== vals[i]) begin
            errors++;
            $display("[TB] FAIL basic_stored: got %h/%h expected %h", rdata_a[3], rdata_b[1], vals[i]);
         end
      end
   endtask

   task automatic test_zero_reg();
      @(negedge clk);
      we_a = 2'b11;
      wa_a = {5'd31, 5'd31};
      wd_a = {64'h1, 64'hFFFF};
      rd_a = {4{5'd31}};
      #1;
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (rdata_a[r] !== 64'd0) begin
            errors++;
            $display("[TB] FAIL zero_during%0d: got %h expected 0", r, rdata_a[r]);
         end
      end
      step();
      checks++;
      if (conf_a !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_conflict: got %b expected 0", conf_a);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (rdata_a[r] !== 64'd0) begin
            errors++;
            $display("[TB] FAIL zero_after%0d: got %h expected 0", r, rdata_a[r]);
         end
      end
   endtask

   task automatic test_collision();
      @(negedge clk);
      we_a = 2'b11;
      wa_a = {5'd7, 5'd7};
      wd_a = {64'd2, 64'd1};
      rd_a[0] = 5'd7;
      #1;
      checks++;
      if (rdata_a[0] !== 64'd2) begin
         errors++;
         $display("[TB] FAIL collide_bypass: got %h expected 2", rdata_a[0]);
      end
      step();
      checks++;
      if (conf_a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL collide_flag_on: got %b expected 1", conf_a);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (rdata_a[0] !== 64'd2) begin
         errors++;
         $display("[TB] FAIL collide_winner: got %h expected 2", rdata_a[0]);
      end
      step();
      checks++;
      if (conf_a !== 1'b0) begin
         errors++;
         $display("[TB] FAIL collide_flag_off: got %b expected 0", conf_a);
      end
   endtask

   task automatic test_multi_read();
      @(negedge clk);
      we_a = 2'b11; wa_a = {5'd2, 5'd1}; wd_a = {64'd20, 64'd10};
      step();
      @(negedge clk);
      wa_a = {5'd4, 5'd3}; wd_a = {64'd40, 64'd30};
      step();
      @(negedge clk);
      idle_inputs();
      rd_a = {5'd1, 5'd2, 5'd3, 5'd4};
      #1;
      checks++;
      if (rdata_a !== {64'd10, 64'd20, 64'd30, 64'd40}) begin
         errors++;
         $display("[TB] FAIL multi_distinct: got %h expected 40,30,20,10 on ports 0..3", rdata_a);
      end
      rd_a = {4{5'd3}};
      #1;
      checks++;
      if (rdata_a !== {4{64'd30}}) begin
         errors++;
         $display("[TB] FAIL multi_same: got %h expected all 30", rdata_a);
      end
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         we_b = 1'b1; wa_b[0] = 4'(i); wd_b[0] = $urandom;
         step();
      end
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 16; i += 2) begin
         rd_b = {4'(i + 1), 4'(i)};
         #1;
         checks++;
         if (rdata_b[0] !== model_b(4'(i)) || rdata_b[1] !== model_b(4'(i + 1))) begin
            errors++;
            $display("[TB] FAIL sweep_x%0d: got %h/%h expected %h/%h", i, rdata_b[0], rdata_b[1],
                     model_b(4'(i)), model_b(4'(i + 1)));
         end
      end
   endtask

   task automatic checkOutput();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_zero_reg();
      test_collision();
      test_multi_read();
      test_sweep();
      applyStimulus(300);
      checkOutput();
      $finish;
   end

endmodule
